cyclic_lamp: RTL and testbench
==============================

Name: cyclic_lamp

Overview:
Moore finite-state machine that drives a three-lamp signal head through a fixed cycle: RED, then GREEN, then YELLOW, then back to RED. The output is a pure function of the current state, registered on clk. It is a free-running leaf block with no input other than clock and reset. It feeds lamp drivers or a display decoder directly.

Parameters:
RED_CYCLES, 1, number of clk cycles the RED phase is held (minimum 1).
GREEN_CYCLES, 1, number of clk cycles the GREEN phase is held (minimum 1).
YELLOW_CYCLES, 1, number of clk cycles the YELLOW phase is held (minimum 1).

Ports:
clk  input  1  rising-edge clock; the only clock in the block.
rst  input  1  synchronous, active-high reset.
light  output  3  one-hot lamp vector; bit2=RED, bit1=GREEN, bit0=YELLOW.

Behaviour:
- States: S_RED, S_GREEN, S_YELLOW. The state register is 2 bits; encoding 2'b11 is illegal.
- Output decode (Moore, from the state register only):
  - S_RED -> 3'b100
  - S_GREEN -> 3'b010
  - S_YELLOW -> 3'b001
  - illegal state -> 3'b100
- Exactly one bit of light is high in every cycle after reset. light is never 000 and never multi-hot.
- Dwell counter: width = clog2(max(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES)+1).
  - Cleared to 0 on every state change.
  - Otherwise increments each clk.
- Transition rule: on a rising edge where counter == DWELL(current state)-1:
  - state advances S_RED -> S_GREEN -> S_YELLOW -> S_RED.
  - counter clears to 0.
  - Otherwise the state holds.
- With all defaults = 1, the state advances on every rising edge. light sequence: 100, 010, 001, 100, ...
- Reset (rst=1 at a rising edge): state=S_RED, counter=0, so light=3'b100 from the edge onward.
  - Reset mid-phase (any state, any count) behaves identically and takes priority over advancing.
- After rst deasserts, the first advance to GREEN occurs on the RED_CYCLES-th rising edge with rst=0.
- Illegal state recovery: the state goes to S_RED with counter 0 on the next edge, even without reset.
- Before the first reset the state is undefined. Verification applies reset before checking.
- Parameter values below 1 are treated as 1 (elaboration-time clamp). No runtime configuration.
- No combinational path from any input to light; light changes only after rising clk edges.

Decomposition:
- Package cyclic_lamp_pkg holds:
  - the state enum (S_RED=2'd0, S_GREEN=2'd1, S_YELLOW=2'd2);
  - light constants LIGHT_RED=3'b100, LIGHT_GREEN=3'b010, LIGHT_YELLOW=3'b001;
  - a function mapping state to light.
- One sub-module, lamp_dwell_timer, is natural: parameterised counter width, inputs clk, rst, clear, terminal count; output done.
- The FSM and output decode stay in cyclic_lamp.

Test Plan:
- Reset then free run, defaults: rst=1 for 2 edges, then 0. light=100 after the reset edge, then 010, 001, 100, 010 on successive edges (100 ns run at 10 ns period).
- Mid-cycle reset: in S_GREEN (light=010), assert rst for one edge -> light=100 on that edge. The next edge with rst=0 gives 010 (defaults).
- Dwell parameters RED=3, GREEN=2, YELLOW=1: after reset, light is 100 for 3 edges, 010 for 2, 001 for 1, then 100 again. Full period = 6 cycles.
- One-hot invariant: over 1000 cycles with random rst pulses, assert popcount(light)==1 every cycle after the first reset.
- Illegal state: force the state register to 2'b11 -> light=100 immediately, and state=S_RED with counter 0 after the next edge.
- Reset held: rst=1 for 20 edges -> light stays 100 throughout, and the counter never advances state.

Source files
------------

// File: rtl/cyclic_lamp_pkg.sv
// cyclic_lamp_pkg: shared types and constants for the cyclic_lamp signal head.
//   state_t        - 2-bit FSM state; 2'b11 is never a legal encoding
//   LIGHT_*        - one-hot lamp vectors, bit2=RED, bit1=GREEN, bit0=YELLOW
//   state_to_light - Moore output decode; anything unrecognised shows RED
package cyclic_lamp_pkg;

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;

  // RED is the fail-safe aspect, so the illegal encoding decodes to it.
  function automatic logic [2:0] state_to_light(input state_t s);
    case (s)
      S_GREEN:  return LIGHT_GREEN;
      S_YELLOW: return LIGHT_YELLOW;
      default:  return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/lamp_dwell_timer.sv
// lamp_dwell_timer: free-running phase counter with terminal-count detect.
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, clears the count
//   clear - synchronous clear (asserted by the FSM on every state change)
//   term  - terminal count for the current phase (dwell - 1)
//   done  - high while the count equals term
module lamp_dwell_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  assign done = (r_cnt == term);

  always_ff @(posedge clk) begin
    if (rst || clear) r_cnt <= '0;
    else              r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/cyclic_lamp.sv
// cyclic_lamp: Moore FSM cycling a three-lamp head RED -> GREEN -> YELLOW.
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (forces RED, restarts the dwell)
//   light - one-hot lamp vector {RED, GREEN, YELLOW}, decoded from the
//           state register only, so it has no path from any input
// Each phase is held for its *_CYCLES edges; values below 1 act as 1.
module cyclic_lamp
  import cyclic_lamp_pkg::*;
#(
  parameter int RED_CYCLES    = 1,
  parameter int GREEN_CYCLES  = 1,
  parameter int YELLOW_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light
);

  localparam int R_C   = (RED_CYCLES    < 1) ? 1 : RED_CYCLES;
  localparam int G_C   = (GREEN_CYCLES  < 1) ? 1 : GREEN_CYCLES;
  localparam int Y_C   = (YELLOW_CYCLES < 1) ? 1 : YELLOW_CYCLES;
  localparam int MAX_C = (R_C > G_C) ? ((R_C > Y_C) ? R_C : Y_C)
                                     : ((G_C > Y_C) ? G_C : Y_C);
  localparam int CNT_W = $clog2(MAX_C + 1);

  state_t           r_state;
  logic [CNT_W-1:0] w_term;
  logic             w_done;
  logic             w_illegal;
  logic             w_clear;

  always_comb begin
    w_term    = '0;
    w_illegal = 1'b0;
    case (r_state)
      S_RED:    w_term = CNT_W'(R_C - 1);
      S_GREEN:  w_term = CNT_W'(G_C - 1);
      S_YELLOW: w_term = CNT_W'(Y_C - 1);
      default:  w_illegal = 1'b1;
    endcase
  end

  // Any state change (normal advance or illegal recovery) restarts the dwell.
  assign w_clear = w_done | w_illegal;

  lamp_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .term  (w_term),
    .done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RED;
    end else begin
      case (r_state)
        S_RED:    if (w_done) r_state <= S_GREEN;
        S_GREEN:  if (w_done) r_state <= S_YELLOW;
        S_YELLOW: if (w_done) r_state <= S_RED;
        default:  r_state <= S_RED;
      endcase
    end
  end

  assign light = state_to_light(r_state);

endmodule

// File: tb/tb_cyclic_lamp.sv
// tb_cyclic_lamp: scoreboard bench for two cyclic_lamp instances, one with
// default dwells (1/1/1) and one with RED=3, GREEN=2, YELLOW=1. The reference
// model tracks edges since the last reset and maps that position within the
// period to a lamp; stimulus pushes the expectation, a negedge monitor checks.
module tb_cyclic_lamp;
  import cyclic_lamp_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light_a, light_b;

  always #5 clk = ~clk;

  cyclic_lamp u_dut_a (.clk(clk), .rst(rst), .light(light_a));

  cyclic_lamp #(.RED_CYCLES(3), .GREEN_CYCLES(2), .YELLOW_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .light(light_b));

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   stim_done = 1'b0;

  // Model state: edges since the last reset edge, and whether reset was seen.
  int ta = 0, tb = 0;
  bit va = 1'b0, vb = 1'b0;

  function automatic logic [2:0] model_light(input int t, input int r,
                                             input int g, input int y);
    int p;
    p = t % (r + g + y);
    if (p < r)     return 3'b100;
    if (p < r + g) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(input string name, input logic [2:0] act,
                       input logic [2:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
  endtask

  // One clock of stimulus; kill_b forces dut_b into the illegal encoding.
  task automatic step(input logic r, input bit kill_b);
    exp_t e;
    @(negedge clk);
    #2;
    rst = r;
    if (kill_b) begin
      force u_dut_b.r_state = state_t'(2'b11);
      #1;
      check("illegal_decode", light_b, 3'b100);
      release u_dut_b.r_state;
    end
    @(posedge clk);
    if (r) begin
      ta = 0; tb = 0; va = 1'b1; vb = 1'b1;
    end else begin
      if (va) ta++;
      if (kill_b) tb = 0;
      else if (vb) tb++;
    end
    if (va && vb) begin
      e.a = model_light(ta, 1, 1, 1);
      e.b = model_light(tb, 3, 2, 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: one expectation per rising edge, checked on the following negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seq_default", light_a, e.a);
        check("seq_321", light_b, e.b);
        n_total++;
        if ($countones(light_a) == 1 && $countones(light_b) == 1) n_pass++;
        else $display("FAIL onehot: got a=%b b=%b, required exactly one bit each",
                      light_a, light_b);
      end
    end
  end

  initial begin
    // Reset, then free run through several full periods.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0);
    // Single-edge reset partway through a phase.
    step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    // Random reset pulses.
    for (int i = 0; i < 1000; i++) step($urandom_range(0, 19) == 0, 1'b0);
    // Reset held for 20 edges.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    // Illegal-state recovery without reset, a few times at varied points.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1);
      for (int i = 0; i < 5 + k; i++) step(1'b0, 1'b0);
    end
    @(negedge clk);
    #3;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    stim_done = 1'b1;
  end

  initial begin
    int cyc = 0;
    while (!stim_done && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    if (!stim_done) begin
      n_total++;
      $display("FAIL timeout: stimulus still running after %0d cycles, required done", cyc);
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
